ram_test_master: RTL and testbench

Avalon-MM initiator that exercises a 32-bit word-addressed on-chip RAM slave: on a start pulse it writes a deterministic pattern over a programmable window, reads the window back, and reports mismatches. It connects to the RAM slave port (single-port, 4-bit byteenable, one-cycle read latency) through the system interconnect. It handles waitrequest and readdatavalid, so it also works behind an arbitrating fabric.

---
 rtl/ram_test_pkg.sv | 19 +
 rtl/ram_test_compare.sv | 52 +++++
 rtl/ram_test_master.sv | 158 +++++++++++++++
 tb/tb_ram_test_master.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_test_pkg.sv
// Shared types and helpers for the RAM test master: FSM states, byte-enable constant
// and the deterministic data pattern.
package ram_test_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdReq,
        StRdWait,
        StDone
    } state_e;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;

    function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [31:0] idx);
        return seed + idx;
    endfunction

endpackage

// File: rtl/ram_test_compare.sv
// Registered read-back compare with a saturating error counter and a first-error
// address latch.
module ram_test_compare #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [31:0]       i_rdata,
    input  logic [31:0]       i_expected,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [ERR_W-1:0]  o_err_count,
    output logic [ADDR_W-1:0] o_first_err_addr
);

    logic              r_mismatch;
    logic [ADDR_W-1:0] r_mismatch_addr;
    logic [ERR_W-1:0]  r_err_count;
    logic [ADDR_W-1:0] r_first_err_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mismatch       <= 1'b0;
            r_mismatch_addr  <= '0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
        end else if (i_clear) begin
            r_mismatch       <= 1'b0;
            r_mismatch_addr  <= '0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
        end else begin
            r_mismatch      <= i_en && (i_rdata != i_expected);
            r_mismatch_addr <= i_addr;
            if (r_mismatch) begin
                // A zero count means no earlier mismatch in this run.
                if (r_err_count == '0) begin
                    r_first_err_addr <= r_mismatch_addr;
                end
                if (!(&r_err_count)) begin
                    r_err_count <= r_err_count + {{(ERR_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign o_err_count      = r_err_count;
    assign o_first_err_addr = r_first_err_addr;

endmodule

// File: rtl/ram_test_master.sv
// Avalon-MM initiator: writes seed+idx over a wrapped address window, reads it back
// one outstanding read at a time and counts mismatches.
module ram_test_master
    import ram_test_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   length,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    input  logic [31:0]       readdata,
    input  logic              waitrequest,
    input  logic              readdatavalid
);

    state_e            r_state;
    logic [ADDR_W:0]   r_idx;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_seed;
    logic              r_busy;
    logic              r_done;
    logic              r_cs;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic              w_start;
    logic              w_accept;
    logic              w_rd_valid;
    logic              w_last;
    logic [ADDR_W:0]   w_idx_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [31:0]       w_expected;

    assign w_start    = (r_state == StIdle) && start;
    assign w_accept   = r_cs && !waitrequest;
    assign w_rd_valid = (r_state == StRdWait) && readdatavalid;
    assign w_idx_nxt  = r_idx + {{ADDR_W{1'b0}}, 1'b1};
    assign w_last     = (w_idx_nxt == r_len);
    assign w_addr_nxt = r_base + w_idx_nxt[ADDR_W-1:0];
    assign w_expected = pattern(r_seed, 32'(r_idx));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_len   <= '0;
            r_base  <= '0;
            r_seed  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cs    <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (r_done) begin
                        r_busy <= 1'b0;
                    end
                    if (start) begin
                        r_base <= base;
                        r_len  <= length;
                        r_seed <= seed;
                        r_idx  <= '0;
                        r_busy <= 1'b1;
                        if (length != '0) begin
                            r_state <= StWr;
                            r_cs    <= 1'b1;
                            r_write <= 1'b1;
                            r_addr  <= base;
                            r_wdata <= pattern(seed, 32'd0);
                        end else begin
                            r_state <= StDone;
                        end
                    end
                end
                StWr: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_idx   <= '0;
                            r_addr  <= r_base;
                            r_write <= 1'b0;
                            r_state <= StRdReq;
                        end else begin
                            r_idx   <= w_idx_nxt;
                            r_addr  <= w_addr_nxt;
                            r_wdata <= pattern(r_seed, 32'(w_idx_nxt));
                        end
                    end
                end
                StRdReq: begin
                    if (w_accept) begin
                        r_cs    <= 1'b0;
                        r_state <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (readdatavalid) begin
                        if (w_last) begin
                            r_state <= StDone;
                        end else begin
                            r_idx   <= w_idx_nxt;
                            r_addr  <= w_addr_nxt;
                            r_cs    <= 1'b1;
                            r_state <= StRdReq;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    ram_test_compare #(
        .ADDR_W(ADDR_W),
        .ERR_W (ERR_W)
    ) u_compare (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_clear         (w_start),
        .i_en            (w_rd_valid),
        .i_rdata         (readdata),
        .i_expected      (w_expected),
        .i_addr          (r_addr),
        .o_err_count     (err_count),
        .o_first_err_addr(first_err_addr)
    );

    assign busy       = r_busy;
    assign done       = r_done;
    assign address    = r_addr;
    assign chipselect = r_cs;
    assign write      = r_write;
    assign writedata  = r_wdata;
    assign byteenable = r_cs ? BYTEEN_ALL : 4'h0;

endmodule

// File: tb/tb_ram_test_master.sv
// Directed bench for ram_test_master with a behavioural single-port RAM slave
// (optional random stalls, variable read latency, single-bit read fault).
module tb_ram_test_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base = '0;
    logic [10:0] length = '0;
    logic [31:0] seed = '0;
    logic        busy, done;
    logic [15:0] err_count;
    logic [9:0]  first_err_addr;
    logic [9:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect, write;
    logic [31:0] writedata;
    logic [31:0] readdata = '0;
    logic        waitrequest = 1'b0;
    logic        readdatavalid = 1'b0;

    always #5 clk = ~clk;

    ram_test_master #(
        .ADDR_W(10),
        .ERR_W (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .base          (base),
        .length        (length),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .address       (address),
        .byteenable    (byteenable),
        .chipselect    (chipselect),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .waitrequest   (waitrequest),
        .readdatavalid (readdatavalid)
    );

    // RAM slave model
    logic [31:0] mem [1024];
    bit          stall_en = 1'b0;
    bit          lat_rand = 1'b0;
    bit          fault_en = 1'b0;
    logic [9:0]  fault_addr = 10'd5;
    int          n_wr = 0, n_rd = 0, cs_cycles = 0, stall_viol = 0, done_cnt = 0;
    logic [9:0]  wr_log [$];
    logic [9:0]  rd_log [$];
    bit          rd_pend = 1'b0;
    int          rd_lat = 0;
    logic [31:0] rd_data = '0;
    bit          hold = 1'b0;
    logic [42:0] held = '0;

    always @(posedge clk) begin
        if (!reset_n) begin
            rd_pend = 1'b0;
            hold = 1'b0;
            readdatavalid <= 1'b0;
            waitrequest <= 1'b0;
        end else begin
            readdatavalid <= 1'b0;
            if (chipselect) cs_cycles++;
            if (hold && (!chipselect || {address, writedata, write} != held)) stall_viol++;
            hold = chipselect && waitrequest;
            held = {address, writedata, write};
            if (rd_pend) begin
                rd_lat--;
                if (rd_lat == 0) begin
                    readdatavalid <= 1'b1;
                    readdata <= rd_data;
                    rd_pend = 1'b0;
                end
            end
            if (chipselect && !waitrequest) begin
                if (write) begin
                    mem[address] = writedata;
                    n_wr++;
                    wr_log.push_back(address);
                end else begin
                    n_rd++;
                    rd_log.push_back(address);
                    rd_data = mem[address] ^ ((fault_en && address == fault_addr) ? 32'd1 : 32'd0);
                    rd_lat = lat_rand ? int'($urandom_range(1, 4)) : 1;
                    if (rd_lat == 1) begin
                        readdatavalid <= 1'b1;
                        readdata <= rd_data;
                    end else begin
                        rd_lat--;
                        rd_pend = 1'b1;
                    end
                end
            end
            waitrequest <= stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    always @(posedge clk) if (done) done_cnt++;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    int          cyc;
    bit          got_done;
    logic [3:0]  be1;
    logic        busy1, busy_after;
    logic [15:0] err_at_done;
    logic [9:0]  first_at_done;
    int          w0, r0, d0, cs0, v0;

    task automatic run(input logic [9:0] b, input logic [10:0] l, input logic [31:0] s,
                       input int poke, input int limit);
        w0 = n_wr; r0 = n_rd; d0 = done_cnt; cs0 = cs_cycles; v0 = stall_viol;
        got_done = 1'b0;
        @(negedge clk);
        base = b; length = l; seed = s; start = 1'b1;
        cyc = 0;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                be1 = byteenable;
                busy1 = busy;
            end
            if (poke != 0 && cyc == poke) begin
                start = 1'b1; base = 10'h155; length = 11'd2; seed = 32'h0;
            end
            if (done) begin
                got_done = 1'b1;
                err_at_done = err_count;
                first_at_done = first_err_addr;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        busy_after = busy;
        check("done_seen", got_done, 1'b1);
    endtask

    logic [9:0] wrap_exp [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cs", chipselect, 1'b0);
        check("rst_write", write, 1'b0);
        check("rst_addr", address, 10'h0);
        check("rst_wdata", writedata, 32'h0);
        check("rst_be", byteenable, 4'h0);
        check("rst_err", err_count, 16'h0);
        check("rst_first", first_err_addr, 10'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean run
        run(10'h0, 11'd16, 32'h1000, 0, 200);
        check("clean_cycles", cyc, 50);
        check("clean_busy1", busy1, 1'b1);
        check("clean_be", be1, 4'hF);
        check("clean_err", err_at_done, 16'h0);
        check("clean_nwr", n_wr - w0, 16);
        check("clean_nrd", n_rd - r0, 16);
        check("clean_mem0", mem[0], 32'h1000);
        check("clean_mem15", mem[15], 32'h100F);
        check("clean_busy_after", busy_after, 1'b0);
        check("clean_done_cnt", done_cnt - d0, 1);

        // Address wrap
        run(10'h3FE, 11'd4, 32'hA0, 0, 200);
        check("wrap_cycles", cyc, 14);
        check("wrap_err", err_at_done, 16'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_wr%0d", i), wr_log[w0 + i], wrap_exp[i]);
            check($sformatf("wrap_rd%0d", i), rd_log[r0 + i], wrap_exp[i]);
        end
        check("wrap_mem3fe", mem[10'h3FE], 32'hA0);
        check("wrap_mem1", mem[1], 32'hA3);

        // Injected fault on word 5
        fault_en = 1'b1;
        run(10'h0, 11'd8, 32'hBEEF0000, 0, 200);
        fault_en = 1'b0;
        check("fault_cycles", cyc, 26);
        check("fault_err", err_at_done, 16'd1);
        check("fault_first", first_at_done, 10'd5);
        check("fault_err_hold", err_count, 16'd1);

        // Random stalls and read latency
        stall_en = 1'b1; lat_rand = 1'b1;
        run(10'h100, 11'd20, 32'h55, 0, 2000);
        stall_en = 1'b0; lat_rand = 1'b0;
        @(negedge clk);
        check("stall_err", err_at_done, 16'h0);
        check("stall_nwr", n_wr - w0, 20);
        check("stall_nrd", n_rd - r0, 20);
        check("stall_stable", stall_viol - v0, 0);

        // Zero length
        run(10'h0, 11'd0, 32'h1, 0, 50);
        check("len0_cycles", cyc, 2);
        check("len0_cs", cs_cycles - cs0, 0);
        check("len0_err", err_at_done, 16'h0);

        // Full sweep
        run(10'h200, 11'd1024, 32'hFFFFFF00, 0, 5000);
        check("full_cycles", cyc, 3074);
        check("full_err", err_at_done, 16'h0);
        check("full_nrd", n_rd - r0, 1024);
        check("full_mem1ff", mem[10'h1FF], 32'h000002FF);

        // Start while busy is ignored
        run(10'h0, 11'd4, 32'h10, 3, 200);
        check("busy_start_cycles", cyc, 14);
        check("busy_start_nwr", n_wr - w0, 4);
        check("busy_start_last_addr", wr_log[w0 + 3], 10'd3);
        check("busy_start_mem3", mem[3], 32'h13);

        // Reset in RD_WAIT
        @(negedge clk);
        base = 10'h0; length = 11'd8; seed = 32'h7000; start = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_busy_pre", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_cs", chipselect, 1'b0);
        check("mid_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_no_done", done_cnt - d0, 0);
        run(10'h0, 11'd8, 32'h7000, 0, 200);
        check("rerun_cycles", cyc, 26);
        check("rerun_err", err_at_done, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
